fifo_write_ptr_ctrl: RTL and testbench
======================================

# fifo_write_ptr_ctrl

Parametrised write-side pointer and flag controller for the dual-clock FIFO, running entirely in the write clock domain. It synchronises the read domain's Gray pointer internally, tracks occupancy, and generates `full`, `almost_full`, a sticky overflow flag and the memory write strobe. It supersedes the fixed 8-entry write control logic and drives the FIFO RAM write port and the read-side controller's pointer synchroniser.

## Interface
- `ADDR_W`, default 3: RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits, with the MSB as the wrap bit.
- `SYNC_STAGES`, default 2: depth of the read-pointer synchroniser; legal values are 2 or more.
- `AF_THRESH`, default 6: occupancy at or above which `almost_full` asserts; legal range is 1..2^ADDR_W.

Clock and reset: one clock, `write_clk`; reset `write_rst` is asynchronous and active-low.
- `write_clk` in 1: write-domain clock.
- `write_rst` in 1: asynchronous active-low reset.
- `write_enable` in 1: write request.
- `read_addr_gray` in ADDR_W+1: read pointer in Gray code, asynchronous to `write_clk`.
- `overflow_clr` in 1: clears the sticky `overflow` flag.
- `write_addr` out ADDR_W: RAM write address (low bits of the binary pointer, registered).
- `write_addr_gray` out ADDR_W+1: registered Gray write pointer, sent to the read domain.
- `write_enable_1` out 1: RAM write strobe, combinational, equal to `write_enable & !full`.
- `full` out 1: registered.
- `almost_full` out 1: registered.
- `write_level` out ADDR_W+1: occupancy as seen by the write side, range 0..2^ADDR_W, registered.
- `overflow` out 1: sticky; records that a write was attempted while full.

## Operation
- Reset values: binary pointer 0, `write_addr` 0, `write_addr_gray` 0, `full` 0, `almost_full` 0, `write_level` 0, `overflow` 0, all synchroniser flops 0.
- Accept condition: `write_enable && !full` at a rising edge. On accept, the binary pointer increments modulo 2^(ADDR_W+1) and the Gray pointer becomes bin2gray of the new value.
- Refused writes (`write_enable && full`) leave the pointers unchanged.
- Read pointer path: `read_addr_gray` passes through SYNC_STAGES flops, then gray2bin gives `rbin`.
- All flags are computed from the next pointer `wbin_next` and `rbin`, then registered:
  - `write_level` = (`wbin_next` − `rbin`) mod 2^(ADDR_W+1).
  - `full` = the MSBs differ and the low ADDR_W bits are equal, which is equivalent to `write_level` = 2^ADDR_W.
  - `almost_full` = `write_level_next` ≥ AF_THRESH.
- Overflow flag:
  - Set at the edge where `write_enable && full`.
  - Cleared at the edge where `overflow_clr` is high.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around is natural modulo arithmetic. No special case exists at the 2^(ADDR_W+1) rollover.
- Reset mid-operation forces all state to reset values immediately, whatever the handshake state. The first accept after release writes address 0.

## Timing
- `write_enable_1` is valid in the same cycle as `write_enable`, with zero latency.
- `write_addr`, `write_addr_gray`, `write_level` and `full` update at the edge that accepts the write. `full` is therefore high in the cycle after the filling write.
- A read pointer change that is stable before edge k is reflected in `full`, `almost_full` and `write_level` after edge k+SYNC_STAGES. With the default of 2, the latency is 3 edges.
- The flags are pessimistic:
  - `full` may stay high, and `write_level` may read high, for up to SYNC_STAGES+1 cycles after a read.
  - `full` never deasserts early.
- `write_addr_gray` changes by exactly one bit per accepted write.

## Configuration
- `FIFO_WR_ALMOST_FULL_EN` defined: the threshold compare and the `almost_full` register are built as described above.
- Not defined:
  - `almost_full` is tied to 0.
  - AF_THRESH is ignored.
  - No compare logic or register is built.
  - The port list does not change.

## Structure
- Shared package `fifo_pkg` holds the `bin2gray` and `gray2bin` functions, parametrised on width, and a `PTR_W(ADDR_W)` constant function. The read-side controller reuses this package.
- Sub-module `sync_ff_chain` is a WIDTH × STAGES flop chain with asynchronous active-low reset. It is instantiated once, for `read_addr_gray`.

## Test plan
Defaults apply throughout: ADDR_W=3, SYNC_STAGES=2, AF_THRESH=6, macro defined.
- Reset, write 5 entries, then pulse `write_rst` low mid-burst: all outputs go to 0 asynchronously. After release, the next write uses `write_addr` 0.
- Hold `read_addr_gray`=0 and apply 8 back-to-back writes:
  - `write_addr` steps 1..7 then 0, and `write_addr_gray` steps 0001, 0011, …, 1100.
  - `full` goes to 1 and `write_level` to 8 after the 8th edge.
  - `write_enable_1` is 0 on the 9th request.
- With the FIFO full, hold `write_enable` high:
  - `overflow` sets and the pointers stay frozen.
  - `overflow_clr` together with a refused write keeps `overflow` at 1.
  - `overflow_clr` alone clears it.
- With the FIFO full, set `read_addr_gray`=0001: `full` stays 1 for 2 edges, then drops with `write_level`=7 after the 3rd edge.
- Wrap test: fill with 8 writes, move the read pointer to binary 8 (Gray 1100), then write 8 more. `full` reasserts with binary pointer 0000 and `write_level`=8.
- Almost-full: at `write_level` 5, `almost_full` is 0. The 6th write sets `almost_full` on the same edge that `write_level` becomes 6. With the macro undefined, `almost_full` stays 0 throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the dual-clock FIFO.
package fifo_pkg;

  localparam int MAX_PTR_W = 32;

  function automatic int PTR_W(input int addr_w);
    return addr_w + 1;
  endfunction

  // Callers zero-extend narrower pointers to MAX_PTR_W and cast the result back.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// WIDTH x STAGES flop chain for bringing a Gray pointer into the local clock domain.
module sync_ff_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/fifo_write_ptr_ctrl.sv
// Write-domain pointer, occupancy and flag controller for the dual-clock FIFO.
// Optional almost-full logic is built only when FIFO_WR_ALMOST_FULL_EN is defined.
module fifo_write_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic              write_clk,
  input  logic              write_rst,
  input  logic              write_enable,
  input  logic [ADDR_W:0]   read_addr_gray,
  input  logic              overflow_clr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W:0]   write_addr_gray,
  output logic              write_enable_1,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   write_level,
  output logic              overflow
);

  localparam int PW = PTR_W(ADDR_W);

  if (SYNC_STAGES < 2 || AF_THRESH < 1 || AF_THRESH > (1 << ADDR_W)) begin : g_param_err
    $error("fifo_write_ptr_ctrl: illegal SYNC_STAGES or AF_THRESH");
  end

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] rgray_sync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic          accept;
  logic          full_next;

  sync_ff_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (write_clk),
    .rst_n (write_rst),
    .d     (read_addr_gray),
    .q     (rgray_sync)
  );

  assign accept         = write_enable & ~full;
  assign write_enable_1 = accept;
  assign wbin_next      = wbin + PW'(accept);
  assign rbin           = PW'(gray2bin(MAX_PTR_W'(rgray_sync)));
  assign level_next     = wbin_next - rbin;
  assign full_next      = (wbin_next[PW-1] != rbin[PW-1]) &&
                          (wbin_next[ADDR_W-1:0] == rbin[ADDR_W-1:0]);
  assign write_addr     = wbin[ADDR_W-1:0];

  // Flags are re-evaluated every edge so read-side progress is seen without a write.
  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      wbin            <= '0;
      write_addr_gray <= '0;
      full            <= 1'b0;
      write_level     <= '0;
      overflow        <= 1'b0;
    end else begin
      wbin            <= wbin_next;
      write_addr_gray <= PW'(bin2gray(MAX_PTR_W'(wbin_next)));
      full            <= full_next;
      write_level     <= level_next;
      if (write_enable && full) overflow <= 1'b1;
      else if (overflow_clr)    overflow <= 1'b0;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  logic af_q;

  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) af_q <= 1'b0;
    else            af_q <= (level_next >= AF_T);
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_ptr_ctrl.sv
// Directed bench for fifo_write_ptr_ctrl at default parameters.
module tb_fifo_write_ptr_ctrl;

  logic       write_clk;
  logic       write_rst;
  logic       write_enable;
  logic [3:0] read_addr_gray;
  logic       overflow_clr;
  logic [2:0] write_addr;
  logic [3:0] write_addr_gray;
  logic       write_enable_1;
  logic       full;
  logic       almost_full;
  logic [3:0] write_level;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  // Gray codes of binary 1..8 and of binary 9..15,0.
  logic [3:0] gray_a [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
  logic [3:0] gray_b [8] = '{4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [2:0] addr_x [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [3:0] lvl_x  [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
  logic       af_x   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       full_x [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  fifo_write_ptr_ctrl dut (
    .write_clk       (write_clk),
    .write_rst       (write_rst),
    .write_enable    (write_enable),
    .read_addr_gray  (read_addr_gray),
    .overflow_clr    (overflow_clr),
    .write_addr      (write_addr),
    .write_addr_gray (write_addr_gray),
    .write_enable_1  (write_enable_1),
    .full            (full),
    .almost_full     (almost_full),
    .write_level     (write_level),
    .overflow        (overflow)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(write_addr), 32'd0);
    check({tag, "_gray"},  32'(write_addr_gray), 32'd0);
    check({tag, "_level"}, 32'(write_level), 32'd0);
    check({tag, "_full"},  32'(full), 32'd0);
    check({tag, "_af"},    32'(almost_full), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  initial begin
    write_rst      = 1'b0;
    write_enable   = 1'b0;
    read_addr_gray = 4'h0;
    overflow_clr   = 1'b0;
    repeat (2) tick();
    check_all_zero("rst");
    check("rst_we1", 32'(write_enable_1), 32'd0);
    write_rst = 1'b1;

    // Five writes, then asynchronous reset mid-burst
    write_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("burst_addr", 32'(write_addr), 32'(addr_x[k]));
      check("burst_level", 32'(write_level), 32'(lvl_x[k]));
    end
    check("burst_gray5", 32'(write_addr_gray), 32'h7);
    #2;
    write_rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    write_rst = 1'b1;
    check("post_rst_addr", 32'(write_addr), 32'd0);
    check("post_rst_we1", 32'(write_enable_1), 32'd1);
    tick();
    check("post_rst_addr1", 32'(write_addr), 32'd1);
    check("post_rst_level1", 32'(write_level), 32'd1);

    // Clean start, then fill with 8 back-to-back writes
    write_enable = 1'b0;
    write_rst = 1'b0;
    #1;
    write_rst = 1'b1;
    check_all_zero("rst2");
    write_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("fill_addr", 32'(write_addr), 32'(addr_x[k]));
      check("fill_gray", 32'(write_addr_gray), 32'(gray_a[k]));
      check("fill_level", 32'(write_level), 32'(lvl_x[k]));
      check("fill_full", 32'(full), 32'(full_x[k]));
      check("fill_af", 32'(almost_full), AF_EN ? 32'(af_x[k]) : 32'd0);
    end
    check("ninth_we1", 32'(write_enable_1), 32'd0);

    // Overflow while full
    tick();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_addr", 32'(write_addr), 32'd0);
    check("ovf_gray", 32'(write_addr_gray), 32'hC);
    check("ovf_level", 32'(write_level), 32'd8);
    overflow_clr = 1'b1;
    tick();
    check("ovf_set_wins", 32'(overflow), 32'd1);
    write_enable = 1'b0;
    tick();
    check("ovf_clr", 32'(overflow), 32'd0);
    overflow_clr = 1'b0;

    // One read: full drops after three edges
    read_addr_gray = 4'h1;
    tick();
    check("rd_full_e1", 32'(full), 32'd1);
    tick();
    check("rd_full_e2", 32'(full), 32'd1);
    check("rd_level_e2", 32'(write_level), 32'd8);
    tick();
    check("rd_full_e3", 32'(full), 32'd0);
    check("rd_level_e3", 32'(write_level), 32'd7);
    check("rd_af_e3", 32'(almost_full), AF_EN ? 32'd1 : 32'd0);

    // Read pointer to binary 8, then wrap with 8 more writes
    read_addr_gray = 4'hC;
    tick();
    tick();
    check("wrap_level_pess", 32'(write_level), 32'd7);
    tick();
    check("wrap_level0", 32'(write_level), 32'd0);
    check("wrap_af0", 32'(almost_full), 32'd0);
    write_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("wrap_addr", 32'(write_addr), 32'(addr_x[k]));
      check("wrap_gray", 32'(write_addr_gray), 32'(gray_b[k]));
      check("wrap_level", 32'(write_level), 32'(lvl_x[k]));
      check("wrap_full", 32'(full), 32'(full_x[k]));
    end
    write_enable = 1'b0;
    tick();
    check("wrap_hold_full", 32'(full), 32'd1);
    check("wrap_hold_gray", 32'(write_addr_gray), 32'h0);
    check("wrap_hold_ovf", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
